// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot with full/seq tracking and valid/ready handshake.
module wb_slot
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  output logic              ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              grant,
  input  logic              load_seq,
  input  logic              clear_seq,
  output logic              full,
  output logic              seq,
  output logic [ADDR_W-1:0] slot_addr,
  output logic [DATA_W-1:0] slot_data
);

  logic load;

  // A granted slot frees up in the same edge, so it can take a new entry back to back.
  assign ready = ~full | grant;
  assign load  = valid & ready & (addr != ADDR_W'(ZERO_REG));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      seq  <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      seq  <= load_seq;
    end else if (grant) begin
      full <= 1'b0;
      seq  <= 1'b0;
    end else if (clear_seq) begin
      seq  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      slot_addr <= addr;
      slot_data <= data;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port,
// keeping same-destination writes in age order and flagging read hazards.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic              stall,
  output logic              rf_reg_write,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [15:0]       wr_count
);

  logic              full0, full1, seq0, seq1;
  logic              gnt0, gnt1, rr, load0, both;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] data0, data1;

  assign load0 = req0_valid & req0_ready & (req0_addr != ADDR_W'(ZERO_REG));

  // A new entry is newer whenever the other slot still holds something after this edge;
  // on a simultaneous load requester 1 is treated as the newer one.
  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot0 (
    .clk       (clk),
    .reset     (reset),
    .valid     (req0_valid),
    .ready     (req0_ready),
    .addr      (req0_addr),
    .data      (req0_data),
    .grant     (gnt0),
    .load_seq  (full1 & ~gnt1),
    .clear_seq (gnt1),
    .full      (full0),
    .seq       (seq0),
    .slot_addr (addr0),
    .slot_data (data0)
  );

  wb_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot1 (
    .clk       (clk),
    .reset     (reset),
    .valid     (req1_valid),
    .ready     (req1_ready),
    .addr      (req1_addr),
    .data      (req1_data),
    .grant     (gnt1),
    .load_seq  ((full0 & ~gnt0) | load0),
    .clear_seq (gnt0),
    .full      (full1),
    .seq       (seq1),
    .slot_addr (addr1),
    .slot_data (data1)
  );

  assign both = full0 & full1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (both) begin
      if (addr0 == addr1) begin
        gnt0 = ~seq0;
        gnt1 = seq0;
      end else begin
        gnt0 = ~rr;
        gnt1 = rr;
      end
    end else begin
      gnt0 = full0;
      gnt1 = full1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr       <= 1'b0;
      wr_count <= '0;
    end else begin
      if (both) rr <= gnt0;
      if (gnt0 | gnt1) wr_count <= wr_count + 16'd1;
    end
  end

  always_comb begin
    rf_reg_write  = gnt0 | gnt1;
    rf_write_addr = '0;
    rf_write_data = '0;
    if (gnt0) begin
      rf_write_addr = addr0;
      rf_write_data = data0;
    end else if (gnt1) begin
      rf_write_addr = addr1;
      rf_write_data = data1;
    end
  end

  assign stall = (full0 & ((addr0 == rd_addr_1) | (addr0 == rd_addr_2))) |
                 (full1 & ((addr1 == rd_addr_1) | (addr1 == rd_addr_2)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scoreboard bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [4:0]  req0_addr, req1_addr, rd_addr_1, rd_addr_2;
  logic [31:0] req0_data, req1_data;
  logic        stall, rf_reg_write;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic [15:0] wr_count;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  regfile_wb_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_addr     (req0_addr),
    .req0_data     (req0_data),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_addr     (req1_addr),
    .req1_data     (req1_data),
    .rd_addr_1     (rd_addr_1),
    .rd_addr_2     (rd_addr_2),
    .stall         (stall),
    .rf_reg_write  (rf_reg_write),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .wr_count      (wr_count)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: every register-file write must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset === 1'b0 && rf_reg_write === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                 rf_write_addr, rf_write_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("wr_addr", {27'b0, rf_write_addr}, {27'b0, e.a});
        check("wr_data", rf_write_data, e.d);
      end
    end
  end

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    q.push_back(e);
  endtask

  // Present one request and return just after the edge that accepts it.
  task automatic send(input int r, input logic [4:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    if (r == 0) begin
      req0_valid = 1'b1; req0_addr = a; req0_data = d;
    end else begin
      req1_valid = 1'b1; req1_addr = a; req1_data = d;
    end
    while (((r == 0) ? req0_ready : req1_ready) !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("handshake_timeout", (n < 50) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_pending", q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    rd_addr_1 = '0; rd_addr_2 = '0;
    repeat (2) @(negedge clk);
    check("rst_rf_reg_write", rf_reg_write, 0);
    check("rst_rf_write_addr", rf_write_addr, 0);
    check("rst_rf_write_data", rf_write_data, 0);
    check("rst_stall", stall, 0);
    check("rst_ready0", req0_ready, 1);
    check("rst_ready1", req1_ready, 1);
    check("rst_wr_count", wr_count, 0);
    reset = 1'b0;

    // Single write with a read hazard on port 1
    rd_addr_1 = 5'd5;
    expect_wr(5'd5, 32'hDEADBEEF);
    send(0, 5'd5, 32'hDEADBEEF);
    req0_valid = 1'b0;
    @(negedge clk);
    check("single_stall", stall, 1);
    check("single_write_en", rf_reg_write, 1);
    @(negedge clk);
    check("single_wr_count", wr_count, 1);
    check("single_stall_clear", stall, 0);
    rd_addr_1 = '0;

    // Writes to register zero are swallowed
    @(negedge clk);
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFFFFFF;
    check("zero_ready1", req1_ready, 1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    @(negedge clk);
    check("zero_no_write", rf_reg_write, 0);
    check("zero_stall", stall, 0);
    check("zero_wr_count", wr_count, 1);

    // Contention: strict alternation starting with requester 0
    expect_wr(5'd1, 32'h101);  expect_wr(5'd9, 32'h109);
    expect_wr(5'd2, 32'h102);  expect_wr(5'd10, 32'h10A);
    expect_wr(5'd3, 32'h103);  expect_wr(5'd11, 32'h10B);
    fork
      begin
        send(0, 5'd1, 32'h101); send(0, 5'd2, 32'h102); send(0, 5'd3, 32'h103);
        req0_valid = 1'b0;
      end
      begin
        send(1, 5'd9, 32'h109); send(1, 5'd10, 32'h10A); send(1, 5'd11, 32'h10B);
        req1_valid = 1'b0;
      end
    join
    drain();
    check("contention_wr_count", wr_count, 7);

    // Same destination loaded together: requester 0 is older
    expect_wr(5'd7, 32'h11);
    expect_wr(5'd7, 32'h22);
    fork
      begin send(0, 5'd7, 32'h11); req0_valid = 1'b0; end
      begin send(1, 5'd7, 32'h22); req1_valid = 1'b0; end
    join
    drain();
    check("same_addr_wr_count", wr_count, 9);

    // Reset with both slots full
    fork
      begin send(0, 5'd12, 32'hC0C0); req0_valid = 1'b0; end
      begin send(1, 5'd13, 32'hD0D0); req1_valid = 1'b0; end
    join
    rd_addr_1 = 5'd0; rd_addr_2 = 5'd13;
    #1;
    check("hazard_port2", stall, 1);
    rd_addr_2 = 5'd14;
    #1;
    check("no_hazard", stall, 0);
    rd_addr_1 = 5'd12;
    reset = 1'b1;
    #1;
    check("midrst_write_en", rf_reg_write, 0);
    check("midrst_stall", stall, 0);
    check("midrst_ready0", req0_ready, 1);
    check("midrst_ready1", req1_ready, 1);
    check("midrst_wr_count", wr_count, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_write_en", rf_reg_write, 0);
    check("post_rst_wr_count", wr_count, 0);
    rd_addr_1 = '0; rd_addr_2 = '0;

    // Requester 1 older than a later requester 0 entry to the same register
    expect_wr(5'd4, 32'hA4);
    expect_wr(5'd7, 32'h33);
    expect_wr(5'd7, 32'h44);
    fork
      begin send(0, 5'd4, 32'hA4); send(0, 5'd7, 32'h44); req0_valid = 1'b0; end
      begin send(1, 5'd7, 32'h33); req1_valid = 1'b0; end
    join
    drain();
    check("seq_wr_count", wr_count, 3);

    // 65536 back-to-back commits wrap the counter back to its start value
    for (int i = 0; i < 65536; i++) begin
      @(negedge clk);
      req0_valid = 1'b1;
      req0_addr  = 5'((i % 31) + 1);
      req0_data  = 32'(i) ^ 32'h5A5A0000;
      expect_wr(req0_addr, req0_data);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    drain();
    check("wrap_wr_count", wr_count, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between two writeback requesters: requester 0 is ALU writeback, requester 1 is load/memory writeback. Each requester has a one-entry holding slot and a valid/ready handshake. Grants alternate round-robin, except that same-destination entries always drain oldest-first. The block drives the register file write port directly and raises a read-hazard stall while a read address matches a pending, uncommitted write.

## Interface
Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- req0_valid  in  1  requester 0 (ALU) has a write
- req0_ready  out  1  requester 0 slot can accept
- req0_addr  in  ADDR_W  requester 0 destination register
- req0_data  in  DATA_W  requester 0 write data
- req1_valid, req1_ready, req1_addr, req1_data  same as requester 0, for requester 1 (load)
- rd_addr_1  in  ADDR_W  read port 1 address, for hazard check
- rd_addr_2  in  ADDR_W  read port 2 address, for hazard check
- stall  out  1  a read address hits a pending slot
- rf_reg_write  out  1  register file write enable
- rf_write_addr  out  ADDR_W  register file write address
- rf_write_data  out  DATA_W  register file write data
- wr_count  out  16  committed write counter

## Operation
- Slot state, per requester: full bit, addr, data, seq bit.
  - The seq bit is set on load when the other slot is already full, and marks the entry as newer.
- Accept: a handshake (valid & ready) at a rising edge loads the slot.
  - If the address is 0, the entry is discarded: the slot stays empty and wr_count is unchanged. Writes to $0 never reach the register file.
- ready = !full | granted_this_cycle. Ready is combinational from the grant, so a slot sustains one write per cycle.
- Grant, computed combinationally among full slots:
  - One full slot: grant it.
  - Both full, same addr: grant the slot with seq=0 (older). The newer value therefore lands last.
  - Both full, different addr: grant the slot indicated by round-robin pointer rr. rr toggles to the other requester after every grant made under contention.
  - None full: no grant.
- Port drive: rf_reg_write = any grant; rf_write_addr/rf_write_data = granted slot contents. When idle, drive all three to 0.
- Commit: at the edge where a slot is granted, the slot empties (or reloads if a handshake occurs the same edge) and wr_count increments, wrapping 0xFFFF→0.
- After a commit, the surviving slot's seq bit clears to 0.
- Simultaneous load into both empty slots: req0 gets seq=0, req1 gets seq=1.
- stall = OR over full slots of (slot.addr == rd_addr_1 | slot.addr == rd_addr_2). A full slot never holds address 0, so address 0 never stalls.

## Timing
- Reset values: slots empty, seq=0, rr=0, wr_count=0, rf_reg_write=0, rf_write_addr=0, rf_write_data=0, stall=0, req*_ready=1.
- Latency: accept at edge t puts the entry on the port during cycle t→t+1; the register file captures it at edge t+1. Minimum latency is 1 cycle.
- Throughput:
  - One active requester: 1 write/cycle.
  - Both active: 2 writes per 2 cycles, alternating.
- stall is combinational from the slot state and read addresses, so it is valid in the same cycle.
- Reset asserted mid-operation clears all pending entries immediately; those writes are lost.
- Holding rule: a requester holds valid/addr/data stable until ready. Deasserting valid before the handshake drops the request; that is legal.

## Structure
- Package regfile_pkg holds:
  - constants DATA_W=32, ADDR_W=5, NUM_REGS=32, ZERO_REG=0
  - typedef wb_entry_t {addr, data}
- Sub-module wb_slot: the one-entry buffer with full/seq handling and the ready computation. Instantiate it twice.
- The top level holds grant logic, rr, port muxing, stall and wr_count.

## Test plan
- Single write: req0 addr=5 data=0xDEADBEEF, one cycle → rf_reg_write=1 next cycle with addr 5/0xDEADBEEF; wr_count=1; stall=1 for that cycle when rd_addr_1=5.
- Contention: both requesters valid every cycle with distinct addrs (req0: 1,2,3; req1: 9,10,11) → port order 1,9,2,10,3,11; wr_count=6.
- Same-address ordering: req0 addr=7 data=0x11 one cycle, then req1 addr=7 data=0x22 while slot 0 still blocked → 0x11 committed before 0x22; final reg 7 = 0x22.
- Zero register: req1 addr=0 data=0xFFFFFFFF → ready=1, rf_reg_write stays 0, wr_count unchanged, stall=0 with rd_addr=0.
- Reset mid-flight: both slots full, reset pulsed → rf_reg_write=0 and stall=0 immediately; readies=1; wr_count=0; no write after release.
- Counter wrap: 65536 committed writes → wr_count returns to 0.
